// File: rtl/via_bus_scheduler.sv
// E-clock phase generator and VIA access sequencer: one VIA bus cycle per granted request,
// aligned to E high. The host port and its round-robin arbitration exist only with VIA_SCHED_HOST_EN.
module via_bus_scheduler #(
    parameter int DIV    = 10,
    parameter int E_HIGH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       e_clk,
    output logic       via_rising,
    output logic       via_falling,
    output logic [3:0] via_addr,
    output logic [7:0] via_din,
    output logic       via_wen,
    output logic       via_ren,
    input  logic [7:0] via_dout,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    output logic       cpu_ack,
    output logic [7:0] cpu_rdata,
    input  logic       host_req,
    input  logic       host_we,
    input  logic [3:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic [7:0] host_rdata
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] C_ZERO = CW'(0);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_RISE = CW'(DIV - E_HIGH);
    localparam logic [CW-1:0] C_PRE  = CW'(DIV - E_HIGH - 1);
    localparam logic [CW-1:0] C_WIN  = CW'(DIV - E_HIGH - 2);
    localparam logic [CW-1:0] C_FALL = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACTIVE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic           w_host_req;
    logic           w_pick_host;
    logic           w_grant;
    logic           w_capture;
    logic           w_wen_nxt;
    logic           w_ren_nxt;
    logic           w_cpu_ack_nxt;
    logic           r_we;
    logic           r_gnt_host;
    logic           r_e_clk;
    logic           r_rising;
    logic           r_falling;
    logic [3:0]     r_via_addr;
    logic [7:0]     r_via_din;
    logic           r_wen;
    logic           r_ren;
    logic           r_cpu_ack;
    logic [7:0]     r_cpu_rdata;

`ifdef VIA_SCHED_HOST_EN
    logic           r_last_host;
    logic           r_host_ack;
    logic [7:0]     r_host_rdata;
    logic           w_host_ack_nxt;

    assign w_host_req  = host_req;
    // Host wins only when the CPU is idle or the CPU was served last.
    assign w_pick_host = host_req && (!cpu_req || !r_last_host);
`else
    logic           w_unused_host;

    assign w_host_req    = 1'b0;
    assign w_pick_host   = 1'b0;
    assign w_unused_host = host_req;
`endif

    // Phase counter wrap
    always_comb begin
        w_cnt_nxt = r_cnt + C_ONE;
        if (r_cnt == C_FALL) begin
            w_cnt_nxt = C_ZERO;
        end else begin
            w_cnt_nxt = r_cnt + C_ONE;
        end
    end

    // State and phase counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= C_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_cnt <= C_WIN) && (cpu_req || w_host_req)) begin
                    w_state_nxt = S_SETUP;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETUP: begin
                if (r_cnt == C_PRE) begin
                    w_state_nxt = S_ACTIVE;
                end else begin
                    w_state_nxt = S_SETUP;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == C_FALL) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_ACTIVE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        w_grant       = (r_state == S_IDLE) && (w_state_nxt == S_SETUP);
        w_capture     = (r_state == S_ACTIVE) && (r_cnt == C_FALL) && !r_we;
        w_wen_nxt     = (w_state_nxt == S_ACTIVE) && r_we;
        w_ren_nxt     = (w_state_nxt == S_ACTIVE) && !r_we;
        w_cpu_ack_nxt = (w_state_nxt == S_DONE) && !r_gnt_host;
    end

    // Latch the granted port's request; address and data then hold until the next grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_we       <= 1'b0;
            r_gnt_host <= 1'b0;
            r_via_addr <= 4'h0;
            r_via_din  <= 8'h00;
        end else if (w_grant) begin
            r_we       <= w_pick_host ? host_we    : cpu_we;
            r_gnt_host <= w_pick_host;
            r_via_addr <= w_pick_host ? host_addr  : cpu_addr;
            r_via_din  <= w_pick_host ? host_wdata : cpu_wdata;
        end
    end

    // Registered strobes, enables and CPU completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_e_clk     <= 1'b0;
            r_rising    <= 1'b0;
            r_falling   <= 1'b0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= 8'h00;
        end else begin
            r_e_clk   <= (w_cnt_nxt >= C_RISE);
            r_rising  <= (w_cnt_nxt == C_RISE);
            r_falling <= (w_cnt_nxt == C_FALL);
            r_wen     <= w_wen_nxt;
            r_ren     <= w_ren_nxt;
            r_cpu_ack <= w_cpu_ack_nxt;
            // VIA data sampled on the falling-edge clock, before the read side effect lands
            if (w_capture && !r_gnt_host) begin
                r_cpu_rdata <= via_dout;
            end
        end
    end

`ifdef VIA_SCHED_HOST_EN
    assign w_host_ack_nxt = (w_state_nxt == S_DONE) && r_gnt_host;

    // Host completion and round-robin history
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_host  <= 1'b1;
            r_host_ack   <= 1'b0;
            r_host_rdata <= 8'h00;
        end else begin
            r_host_ack <= w_host_ack_nxt;
            if (w_capture && r_gnt_host) begin
                r_host_rdata <= via_dout;
            end
            if (r_state == S_DONE) begin
                r_last_host <= r_gnt_host;
            end
        end
    end

    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;
`else
    assign host_ack   = 1'b0;
    assign host_rdata = 8'h00;
`endif

    assign e_clk       = r_e_clk;
    assign via_rising  = r_rising;
    assign via_falling = r_falling;
    assign via_addr    = r_via_addr;
    assign via_din     = r_via_din;
    assign via_wen     = r_wen;
    assign via_ren     = r_ren;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = r_cpu_rdata;

endmodule
